// File: rtl/ulpi_pkg.sv
// Shared ULPI register-access types and constants used by the read/write
// sequencers and the register engine.
package ulpi_pkg;

  localparam int unsigned ADDR_W = 6;
  localparam int unsigned DATA_W = 8;

  // Command code the engine places on the ULPI bus for a register read.
  localparam logic [1:0] REG_READ_CMD = 2'b11;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    WAIT_BUSY = 3'd2,
    WAIT_DONE = 3'd3,
    RESP      = 3'd4
  } rd_state_e;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              err;
  } rd_resp_t;

  // Bits needed to hold 0..max_count; never less than one bit.
  function automatic int unsigned ctr_width(input int unsigned max_count);
    int unsigned w;
    w = 1;
    if (max_count > 0) begin
      w = int'($clog2(max_count + 1));
    end
    return w;
  endfunction

endpackage

// File: rtl/ulpi_reg_read_ctrl_if.sv
// Request/response channels between the configuration logic and the
// register-read sequencer.
interface ulpi_reg_read_ctrl_if;
  import ulpi_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic              resp_valid;
  logic              resp_ready;
  logic [DATA_W-1:0] resp_data;
  logic              resp_err;

  modport master (
    output req_valid, req_addr, resp_ready,
    input  req_ready, resp_valid, resp_data, resp_err
  );

  modport slave (
    input  req_valid, req_addr, resp_ready,
    output req_ready, resp_valid, resp_data, resp_err
  );

endinterface

// File: rtl/ulpi_timeout_ctr.sv
// Clear/enable saturating counter with an expired flag, shared by the ULPI
// register sequencers for access timeouts.
module ulpi_timeout_ctr
  import ulpi_pkg::*;
#(
  parameter int unsigned MAX_COUNT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);

  localparam int unsigned   W       = ctr_width(MAX_COUNT);
  localparam logic [W-1:0]  MAX_VAL = W'(MAX_COUNT);

  logic [W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_count <= '0;
    end else if (i_en && (r_count != MAX_VAL)) begin
      r_count <= r_count + 1'b1;
    end
  end

  // Reflects the count before this cycle's increment.
  assign o_expired = (r_count == MAX_VAL);

endmodule

// File: rtl/ulpi_reg_read_ctrl.sv
// Upstream sequencer for the ULPI register-read engine: accepts read
// requests, strobes the engine, and returns the byte or a timeout error.
module ulpi_reg_read_ctrl
  import ulpi_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned MAX_RETRIES    = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  ulpi_reg_read_ctrl_if.slave  bus,
  output logic                 READ_DATA,
  output logic [ADDR_W-1:0]    ADDR,
  input  logic [DATA_W-1:0]    DATA,
  input  logic                 BUSY
);

  localparam int unsigned    RW          = ctr_width(MAX_RETRIES);
  localparam logic [RW-1:0]  RETRY_LIMIT = RW'(MAX_RETRIES);

  rd_state_e          r_state;
  logic               r_req_ready;
  logic               r_resp_valid;
  rd_resp_t           r_resp;
  logic               r_read_data;
  logic [ADDR_W-1:0]  r_addr;
  logic [RW-1:0]      r_retry;

  logic               w_tmr_clr;
  logic               w_tmr_en;
  logic               w_expired;

  // Timer only runs while waiting on the engine; a rising BUSY in
  // WAIT_BUSY restarts it so WAIT_DONE gets its own full budget.
  always_comb begin
    w_tmr_clr = 1'b1;
    w_tmr_en  = 1'b0;
    unique case (r_state)
      WAIT_BUSY: begin
        w_tmr_clr = BUSY;
        w_tmr_en  = ~BUSY;
      end
      WAIT_DONE: begin
        w_tmr_clr = 1'b0;
        w_tmr_en  = 1'b1;
      end
      default: ;
    endcase
  end

  ulpi_timeout_ctr #(
    .MAX_COUNT (TIMEOUT_CYCLES)
  ) u_timer (
    .clk       (clk),
    .rst       (rst),
    .i_clr     (w_tmr_clr),
    .i_en      (w_tmr_en),
    .o_expired (w_expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_req_ready  <= 1'b0;
      r_resp_valid <= 1'b0;
      r_resp       <= '0;
      r_read_data  <= 1'b0;
      r_addr       <= '0;
      r_retry      <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (bus.req_valid && r_req_ready) begin
            r_addr      <= bus.req_addr;
            r_retry     <= '0;
            r_req_ready <= 1'b0;
            r_read_data <= 1'b1;
            r_state     <= START;
          end else begin
            // Never offer a new request while the engine is still busy.
            r_req_ready <= ~BUSY;
          end
        end

        START: begin
          r_read_data <= 1'b0;
          r_state     <= WAIT_BUSY;
        end

        WAIT_BUSY: begin
          if (BUSY) begin
            r_state <= WAIT_DONE;
          end else if (w_expired) begin
            if (r_retry < RETRY_LIMIT) begin
              r_retry     <= r_retry + 1'b1;
              r_read_data <= 1'b1;
              r_state     <= START;
            end else begin
              r_resp.data  <= '0;
              r_resp.err   <= 1'b1;
              r_resp_valid <= 1'b1;
              r_state      <= RESP;
            end
          end
        end

        WAIT_DONE: begin
          if (!BUSY) begin
            r_resp.data  <= DATA;
            r_resp.err   <= 1'b0;
            r_resp_valid <= 1'b1;
            r_state      <= RESP;
          end else if (w_expired) begin
            // The engine cannot be aborted, so no retry from here.
            r_resp.data  <= '0;
            r_resp.err   <= 1'b1;
            r_resp_valid <= 1'b1;
            r_state      <= RESP;
          end
        end

        RESP: begin
          if (bus.resp_ready) begin
            r_resp_valid <= 1'b0;
            r_req_ready  <= ~BUSY;
            r_state      <= IDLE;
          end
        end

        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready  = r_req_ready;
  assign bus.resp_valid = r_resp_valid;
  assign bus.resp_data  = r_resp.data;
  assign bus.resp_err   = r_resp.err;
  assign READ_DATA      = r_read_data;
  assign ADDR           = r_addr;

endmodule

// File: tb/tb_ulpi_reg_read_ctrl.sv
// Bench for ulpi_reg_read_ctrl: an event-timeline model of expected outputs
// per cycle, checked every cycle, plus literal spot checks.
module tb_ulpi_reg_read_ctrl;

  localparam int T     = 8;
  localparam int R     = 2;
  localparam int NCYC  = 1024;
  localparam int NEVER = 1 << 30;

  typedef struct packed {
    logic       rd;
    logic       rv;
    logic       idle;
    logic [5:0] addr;
    logic [7:0] dat;
    logic       err;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       read_data;
  logic [5:0] eng_addr;
  logic [7:0] eng_data = 8'h00;
  logic       busy = 1'b0;

  ulpi_reg_read_ctrl_if bus ();

  ulpi_reg_read_ctrl #(
    .TIMEOUT_CYCLES (T),
    .MAX_RETRIES    (R)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .READ_DATA (read_data),
    .ADDR      (eng_addr),
    .DATA      (eng_data),
    .BUSY      (busy)
  );

  always #5 clk = ~clk;

  int         cyc = 0;
  int         n_checks = 0;
  int         n_fail = 0;
  exp_t       ex [NCYC];
  bit         busy_hist [NCYC];
  bit         rst_hist [NCYC];
  int         b_lo = NEVER;
  int         b_hi = NEVER;
  logic [7:0] e_data = 8'h00;

  always @(posedge clk) cyc <= cyc + 1;

  // Engine stand-in: BUSY follows an absolute cycle window set per test.
  always @(posedge clk) begin
    #1;
    busy     = (cyc >= b_lo) && (cyc <= b_hi);
    eng_data = e_data;
  end

  task automatic chk(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got 0x%0h expected 0x%0h", name, cyc, got, exp);
    end
  endtask

  // Per-cycle compare against the expected timeline.
  always @(negedge clk) begin
    if (cyc >= 2 && cyc < NCYC) begin
      if (rst_hist[cyc-1]) begin
        chk("rst_req_ready", int'(bus.req_ready), 0);
        chk("rst_resp_valid", int'(bus.resp_valid), 0);
        chk("rst_resp_data", int'(bus.resp_data), 0);
        chk("rst_resp_err", int'(bus.resp_err), 0);
        chk("rst_read_data", int'(read_data), 0);
        chk("rst_addr", int'(eng_addr), 0);
      end else begin
        chk("read_data", int'(read_data), int'(ex[cyc].rd));
        chk("resp_valid", int'(bus.resp_valid), int'(ex[cyc].rv));
        chk("req_ready", int'(bus.req_ready), int'(ex[cyc].idle && !busy_hist[cyc-1]));
        if (!ex[cyc].idle) chk("addr", int'(eng_addr), int'(ex[cyc].addr));
        if (ex[cyc].rv) begin
          chk("resp_data", int'(bus.resp_data), int'(ex[cyc].dat));
          chk("resp_err", int'(bus.resp_err), int'(ex[cyc].err));
        end
      end
    end
    if (cyc < NCYC) begin
      busy_hist[cyc] = busy;
      rst_hist[cyc]  = rst;
    end
  end

  task automatic on_hs(input int h, input logic [5:0] a);
    for (int c = h + 1; c < NCYC; c++) begin
      ex[c].idle = 1'b0;
      ex[c].addr = a;
    end
    ex[h+1].rd = 1'b1;
  endtask

  task automatic strobe(input int s);
    ex[s].rd = 1'b1;
  endtask

  task automatic on_resp(input int r, input logic [7:0] d, input logic e);
    for (int c = r; c < NCYC; c++) begin
      ex[c].rv  = 1'b1;
      ex[c].dat = d;
      ex[c].err = e;
    end
  endtask

  task automatic on_accept(input int a);
    for (int c = a + 1; c < NCYC; c++) begin
      ex[c].rv   = 1'b0;
      ex[c].idle = 1'b1;
    end
  endtask

  task automatic on_reset(input int r);
    for (int c = r + 1; c < NCYC; c++) begin
      ex[c].rd   = 1'b0;
      ex[c].rv   = 1'b0;
      ex[c].idle = 1'b1;
      ex[c].addr = 6'h00;
    end
  endtask

  task automatic goto(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic lookat(input int c);
    goto(c);
    @(negedge clk);
  endtask

  task automatic resume();
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input int a);
    goto(a);
    bus.resp_ready = 1'b1;
    on_accept(a);
    resume();
    bus.resp_ready = 1'b0;
  endtask

  // Issue a request; BUSY window is [h+lo, h+hi] (lo < 0: never busy).
  task automatic do_req(input logic [5:0] a, input int lo, input int hi,
                        input logic [7:0] d, output int h);
    bit ok;
    ok = 1'b0;
    h  = -1;
    bus.req_valid = 1'b1;
    bus.req_addr  = a;
    for (int k = 0; k < 20 && !ok; k++) begin
      @(negedge clk);
      if (bus.req_ready) begin
        ok     = 1'b1;
        h      = cyc;
        b_lo   = (lo < 0) ? NEVER : h + lo;
        b_hi   = (lo < 0) ? NEVER : h + hi;
        e_data = d;
        on_hs(h, a);
      end
      resume();
    end
    bus.req_valid = 1'b0;
    if (!ok) begin
      n_checks++;
      n_fail++;
      $display("FAIL handshake addr 0x%0h: req_ready never rose within 20 cycles", a);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $fatal(1);
    end
  endtask

  initial begin
    int h;
    for (int c = 0; c < NCYC; c++) begin
      ex[c]      = '0;
      ex[c].idle = 1'b1;
    end
    bus.req_valid  = 1'b0;
    bus.req_addr   = 6'h00;
    bus.resp_ready = 1'b0;
    rst = 1'b1;
    resume();
    goto(3);
    resume();
    rst = 1'b0;

    // Normal read: BUSY high 5 cycles, falls at h+8 -> resp at h+9.
    do_req(6'h00, 3, 7, 8'h24, h);
    on_resp(h + 9, 8'h24, 1'b0);
    lookat(h + 1);
    chk("t1_strobe", int'(read_data), 1);
    chk("t1_addr", int'(eng_addr), 0);
    resume();
    lookat(h + 9);
    chk("t1_resp_valid", int'(bus.resp_valid), 1);
    chk("t1_resp_data", int'(bus.resp_data), 'h24);
    chk("t1_resp_err", int'(bus.resp_err), 0);
    resume();
    accept(h + 10);

    // Back-pressure for 10 cycles while a stray request is held.
    do_req(6'h2B, 2, 4, 8'hC3, h);
    on_resp(h + 6, 8'hC3, 1'b0);
    bus.req_valid = 1'b1;
    bus.req_addr  = 6'h3F;
    lookat(h + 10);
    chk("t2_bp_data", int'(bus.resp_data), 'hC3);
    chk("t2_bp_ready", int'(bus.req_ready), 0);
    resume();
    goto(h + 16);
    bus.req_valid = 1'b0;
    accept(h + 16);
    lookat(h + 17);
    chk("t2_idle_ready", int'(bus.req_ready), 1);
    chk("t2_idle_valid", int'(bus.resp_valid), 0);
    resume();

    // BUSY never rises: strobes every T+2 cycles, error after 3 attempts.
    do_req(6'h11, -1, -1, 8'hFF, h);
    strobe(h + 1 + (T + 2));
    strobe(h + 1 + 2 * (T + 2));
    on_resp(h + 31, 8'h00, 1'b1);
    lookat(h + 21);
    chk("t3_third_strobe", int'(read_data), 1);
    resume();
    lookat(h + 31);
    chk("t3_err", int'(bus.resp_err), 1);
    chk("t3_data", int'(bus.resp_data), 0);
    resume();
    accept(h + 33);

    // BUSY answers the second strobe only.
    do_req(6'h05, 13, 16, 8'h5A, h);
    strobe(h + 11);
    on_resp(h + 18, 8'h5A, 1'b0);
    lookat(h + 18);
    chk("t4_data", int'(bus.resp_data), 'h5A);
    resume();
    accept(h + 19);

    // BUSY stuck high: WAIT_DONE timeout, then req_ready held low until BUSY drops.
    do_req(6'h3E, 2, 19, 8'hEE, h);
    on_resp(h + 12, 8'h00, 1'b1);
    accept(h + 13);
    lookat(h + 18);
    chk("t5_ready_busy", int'(bus.req_ready), 0);
    resume();
    lookat(h + 21);
    chk("t5_ready_free", int'(bus.req_ready), 1);
    resume();

    // BUSY rises on the very cycle the WAIT_BUSY timeout fires: no retry.
    do_req(6'h07, 10, 12, 8'h81, h);
    on_resp(h + 14, 8'h81, 1'b0);
    lookat(h + 11);
    chk("t6_no_retry", int'(read_data), 0);
    resume();
    accept(h + 14);

    // BUSY falls on the very cycle the WAIT_DONE timeout fires: data wins.
    do_req(6'h20, 2, 10, 8'h3C, h);
    on_resp(h + 12, 8'h3C, 1'b0);
    lookat(h + 12);
    chk("t7_err", int'(bus.resp_err), 0);
    chk("t7_data", int'(bus.resp_data), 'h3C);
    resume();
    accept(h + 13);

    // Reset in WAIT_DONE, then a fresh read.
    do_req(6'h33, 3, 50, 8'h77, h);
    goto(h + 6);
    rst  = 1'b1;
    b_hi = h + 6;
    on_reset(h + 6);
    resume();
    rst = 1'b0;
    lookat(h + 7);
    chk("t8_rst_addr", int'(eng_addr), 0);
    chk("t8_rst_valid", int'(bus.resp_valid), 0);
    resume();
    do_req(6'h16, 3, 5, 8'h99, h);
    on_resp(h + 7, 8'h99, 1'b0);
    lookat(h + 7);
    chk("t8_data", int'(bus.resp_data), 'h99);
    chk("t8_addr", int'(eng_addr), 'h16);
    resume();
    accept(h + 8);

    goto(cyc + 5);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    n_fail++;
    $display("FAIL watchdog: simulation did not finish by time 100000");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1);
  end

endmodule
